// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and helpers for the asynchronous SRAM port controller.
//   state_t       : access FSM states (IDLE, SETUP, STROBE, DONE)
//   ws_cnt_width  : width of the strobe down-counter for a given wait-state count
//   idx_width     : width of a channel index for a given channel count
//   DEF_*         : default parameter values shared by the interface and modules
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

   localparam int DEF_ADDR_W      = 19;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_NUM_CH      = 2;
   localparam int DEF_WAIT_STATES = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // max(1, clog2(ws+1)): the counter must hold WAIT_STATES itself.
   function automatic int ws_cnt_width(input int ws);
      return (ws < 1) ? 1 : $clog2(ws + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl_if
// Channel-side request/ack bus of the SRAM port controller.
//   req       : per-channel request level
//   req_we    : per-channel 1=write, 0=read
//   req_addr  : channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata : channel i at [i*DATA_W +: DATA_W]
//   ack       : one-cycle completion pulse, one-hot or zero
//   rdata     : read data, valid while ack is high for a read
//   busy      : controller is not idle
// Modports: master (requesters), slave (controller).
// -----------------------------------------------------------------------------
interface sram_port_ctrl_if
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_CH = DEF_NUM_CH
);

   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        req_we;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_wdata;
   logic [NUM_CH-1:0]        ack;
   logic [DATA_W-1:0]        rdata;
   logic                     busy;

   modport master (
      output req, req_we, req_addr, req_wdata,
      input  ack, rdata, busy
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata,
      output ack, rdata, busy
   );

endinterface

// File: rtl/sram_arb.sv
// -----------------------------------------------------------------------------
// sram_arb
// Channel arbiter for the SRAM port controller.
// Build option SRAM_RR_ARB_EN:
//   defined   : round-robin; search starts at (last granted + 1) mod NUM_CH,
//               pointer advances when en is high (grant taken).
//   undefined : fixed priority, lowest index wins; no pointer state and no
//               clk/reset_n/en ports.
// Ports:
//   clk, reset_n : clock / async active-low reset (round-robin build only)
//   en           : grant is being taken this cycle (round-robin build only)
//   req          : per-channel request
//   grant        : one-hot grant (zero when no request)
//   idx          : binary index of the granted channel
// -----------------------------------------------------------------------------
module sram_arb
   import sram_ctrl_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH
)(
`ifdef SRAM_RR_ARB_EN
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         en,
`endif
   input  logic [NUM_CH-1:0]            req,
   output logic [NUM_CH-1:0]            grant,
   output logic [idx_width(NUM_CH)-1:0] idx
);

   localparam int IDX_W = idx_width(NUM_CH);

`ifdef SRAM_RR_ARB_EN
   logic [IDX_W-1:0] ptr;

   always_comb begin
      int  c;
      logic found;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      c     = 0;
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = int'(ptr) + i;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!found && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = IDX_W'(c);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + IDX_W'(1);
      end
   end
`else
   // Scan downward so the lowest requesting index is the last one written.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl
// Multi-channel controller for an asynchronous byte-wide SRAM. Arbitrates
// NUM_CH request/ack masters and sequences ce_l/oe_l/we_l with a strobe of
// WAIT_STATES+1 clocks: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
// Build option SRAM_RR_ARB_EN selects round-robin arbitration (see sram_arb);
// default build is fixed priority.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   bus          : channel request/ack bus (sram_port_ctrl_if.slave)
//   sram_a       : SRAM address (changes only on the IDLE->SETUP edge)
//   sram_d_o     : SRAM write data (changes only on the IDLE->SETUP edge)
//   sram_d_oe    : pad drive enable for sram_d_o
//   sram_d_i     : SRAM read data from the pad
//   sram_ce_l/oe_l/we_l : active-low SRAM strobes
// All strobes are registered so the pins never glitch.
// -----------------------------------------------------------------------------
module sram_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int WAIT_STATES = DEF_WAIT_STATES
)(
   input  logic              clk,
   input  logic              reset_n,
   sram_port_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_d_o,
   output logic              sram_d_oe,
   input  logic [DATA_W-1:0] sram_d_i,
   output logic              sram_ce_l,
   output logic              sram_oe_l,
   output logic              sram_we_l
);

   localparam int               IDX_W   = idx_width(NUM_CH);
   localparam int               CNT_W   = ws_cnt_width(WAIT_STATES);
   localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                grant_en;
   logic [NUM_CH-1:0]   grant;
   logic [IDX_W-1:0]    grant_idx;
   logic [NUM_CH-1:0]   ch_sel;
   logic                op_we, op_we_nxt;
   logic                ce_l_nxt, oe_l_nxt, we_l_nxt, d_oe_nxt;
   logic [NUM_CH-1:0]   ack_q, ack_nxt;
   logic [DATA_W-1:0]   rdata_q;

   sram_arb #(.NUM_CH(NUM_CH)) u_arb (
`ifdef SRAM_RR_ARB_EN
      .clk     (clk),
      .reset_n (reset_n),
      .en      (grant_en),
`endif
      .req     (bus.req),
      .grant   (grant),
      .idx     (grant_idx)
   );

   // Next-state logic. DONE never looks at req, so a master dropping req on
   // the ack edge cannot start a spurious access.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant_en  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|bus.req) begin
               grant_en  = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_nxt = ST_STROBE;
            cnt_nxt   = WS_LOAD;
         end
         ST_STROBE: begin
            if (cnt == '0) state_nxt = ST_DONE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Strobe values for the state being entered. Write data is driven from
   // SETUP through DONE; oe_l is only low for reads, so d_oe and !oe_l can
   // never coincide, and the IDLE cycle between accesses separates them.
   always_comb begin
      op_we_nxt = grant_en ? bus.req_we[grant_idx] : op_we;
      ce_l_nxt  = (state_nxt == ST_IDLE);
      d_oe_nxt  = op_we_nxt && (state_nxt != ST_IDLE);
      oe_l_nxt  = !(!op_we_nxt && (state_nxt == ST_SETUP || state_nxt == ST_STROBE));
      we_l_nxt  = !(op_we_nxt && state_nxt == ST_STROBE);
      ack_nxt   = (state_nxt == ST_DONE) ? ch_sel : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         op_we     <= 1'b0;
         ch_sel    <= '0;
         sram_a    <= '0;
         sram_d_o  <= '0;
         sram_d_oe <= 1'b0;
         sram_ce_l <= 1'b1;
         sram_oe_l <= 1'b1;
         sram_we_l <= 1'b1;
         ack_q     <= '0;
         rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         op_we     <= op_we_nxt;
         sram_d_oe <= d_oe_nxt;
         sram_ce_l <= ce_l_nxt;
         sram_oe_l <= oe_l_nxt;
         sram_we_l <= we_l_nxt;
         ack_q     <= ack_nxt;
         if (grant_en) begin
            ch_sel   <= grant;
            sram_a   <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            sram_d_o <= bus.req_wdata[grant_idx*DATA_W +: DATA_W];
         end
         // Capture on the edge that leaves STROBE, while oe_l is still low.
         if (state == ST_STROBE && state_nxt == ST_DONE && !op_we) begin
            rdata_q <= sram_d_i;
         end
      end
   end

   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_port_ctrl
// Self-checking bench for sram_port_ctrl. Instance a: NUM_CH=4, WAIT_STATES=1
// with a behavioural SRAM; instances b and c: NUM_CH=1, WAIT_STATES=0 and 15
// with constant pad data. Honours SRAM_RR_ARB_EN for arbitration order.
// -----------------------------------------------------------------------------
module tb_sram_port_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- instance a ----------------
   sram_port_ctrl_if #(.ADDR_W(19), .DATA_W(8), .NUM_CH(4)) a_if ();
   logic [18:0] a_sram_a;
   logic [7:0]  a_d_o, a_d_i;
   logic        a_d_oe, a_ce_l, a_oe_l, a_we_l;

   sram_port_ctrl #(.ADDR_W(19), .DATA_W(8), .NUM_CH(4), .WAIT_STATES(1)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(a_if.slave),
      .sram_a(a_sram_a), .sram_d_o(a_d_o), .sram_d_oe(a_d_oe), .sram_d_i(a_d_i),
      .sram_ce_l(a_ce_l), .sram_oe_l(a_oe_l), .sram_we_l(a_we_l)
   );

   logic [7:0] mem [int];
   always @(posedge clk) if (reset_n && !a_we_l) mem[int'(a_sram_a)] = a_d_o;
   always @(negedge clk)
      a_d_i = (!a_oe_l && mem.exists(int'(a_sram_a))) ? mem[int'(a_sram_a)] : 8'h00;

   int a_we_cum = 0, a_ack_cum = 0, overlap_cnt = 0;
   always @(negedge clk) begin
      if (!a_we_l) a_we_cum++;
      if (a_if.ack != 4'b0) a_ack_cum++;
      if (a_d_oe && !a_oe_l) overlap_cnt++;
   end

   // ---------------- instances b (WS=0) and c (WS=15) ----------------
   sram_port_ctrl_if #(.ADDR_W(19), .DATA_W(8), .NUM_CH(1)) b_if ();
   sram_port_ctrl_if #(.ADDR_W(19), .DATA_W(8), .NUM_CH(1)) c_if ();
   logic [18:0] b_sram_a, c_sram_a;
   logic [7:0]  b_d_o, c_d_o, b_d_i, c_d_i;
   logic        b_d_oe, b_ce_l, b_oe_l, b_we_l, c_d_oe, c_ce_l, c_oe_l, c_we_l;
   assign b_d_i = 8'hC3;
   assign c_d_i = 8'h3C;

   sram_port_ctrl #(.ADDR_W(19), .DATA_W(8), .NUM_CH(1), .WAIT_STATES(0)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(b_if.slave),
      .sram_a(b_sram_a), .sram_d_o(b_d_o), .sram_d_oe(b_d_oe), .sram_d_i(b_d_i),
      .sram_ce_l(b_ce_l), .sram_oe_l(b_oe_l), .sram_we_l(b_we_l)
   );

   sram_port_ctrl #(.ADDR_W(19), .DATA_W(8), .NUM_CH(1), .WAIT_STATES(15)) u_c (
      .clk(clk), .reset_n(reset_n), .bus(c_if.slave),
      .sram_a(c_sram_a), .sram_d_o(c_d_o), .sram_d_oe(c_d_oe), .sram_d_i(c_d_i),
      .sram_ce_l(c_ce_l), .sram_oe_l(c_oe_l), .sram_we_l(c_we_l)
   );

   int b_we_cum = 0, c_we_cum = 0, b_oe_cum = 0, c_oe_cum = 0;
   always @(negedge clk) begin
      if (!b_we_l) b_we_cum++;
      if (!c_we_l) c_we_cum++;
      if (!b_oe_l) b_oe_cum++;
      if (!c_oe_l) c_oe_cum++;
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic a_wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (a_if.busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // One access on instance a; lat counts edges after the sampling edge.
   task automatic a_access(input int ch, input bit we, input logic [18:0] addr,
                           input logic [7:0] wd, output int lat, output logic [3:0] ack_v,
                           output logic [7:0] rd, output logic [18:0] a_v, output int we_low);
      int e, w0;
      bit got;
      a_wait_idle();
      a_if.req_we[ch]              = we;
      a_if.req_addr[ch*19 +: 19]   = addr;
      a_if.req_wdata[ch*8 +: 8]    = wd;
      a_if.req[ch]                 = 1'b1;
      w0 = a_we_cum; e = 0; got = 1'b0; lat = -1; ack_v = '0; rd = '0; a_v = '0;
      while (!got && e < 50) begin
         @(posedge clk); #1;
         e++;
         if (a_if.ack != 4'b0) begin
            got = 1'b1; lat = e - 1; ack_v = a_if.ack; rd = a_if.rdata; a_v = a_sram_a;
         end
      end
      a_if.req[ch] = 1'b0;
      we_low = a_we_cum - w0;
   endtask

   typedef struct {
      int          ch;
      bit          we;
      logic [18:0] addr;
      logic [7:0]  wdata;
      logic [3:0]  exp_ack;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int lat, we_low, snap, n_ord, e;
      logic [3:0]  ack_v;
      logic [7:0]  rd;
      logic [18:0] a_v;
      int ord [8];
      int exp_ord [8];
      int served [2];
      logic doe_h [40];
      logic oel_h [40];
      int doe_fall, oe_fall, n_h, n_ack;
      logic [7:0] rd3;
      int b_lat, c_lat, bw0, cw0, bo0, co0;
      logic [7:0] b_rd, c_rd;
      bit b_done, c_done, hit;

      vecs[0] = '{0, 1'b1, 19'h00000, 8'hAA, 4'b0001, 8'h00};
      vecs[1] = '{0, 1'b0, 19'h00000, 8'h00, 4'b0001, 8'hAA};
      vecs[2] = '{1, 1'b1, 19'h7FFFF, 8'h5A, 4'b0010, 8'hAA};
      vecs[3] = '{1, 1'b0, 19'h7FFFF, 8'h00, 4'b0010, 8'h5A};
      vecs[4] = '{2, 1'b1, 19'h12345, 8'h3C, 4'b0100, 8'h5A};
      vecs[5] = '{3, 1'b0, 19'h12345, 8'h00, 4'b1000, 8'h3C};
      vecs[6] = '{2, 1'b0, 19'h00000, 8'h00, 4'b0100, 8'hAA};
      vecs[7] = '{3, 1'b1, 19'h00000, 8'h11, 4'b1000, 8'hAA};
      vecs[8] = '{0, 1'b0, 19'h00000, 8'h00, 4'b0001, 8'h11};

      a_if.req = '0; a_if.req_we = '0; a_if.req_addr = '0; a_if.req_wdata = '0;
      b_if.req = '0; b_if.req_we = '0; b_if.req_addr = '0; b_if.req_wdata = '0;
      c_if.req = '0; c_if.req_we = '0; c_if.req_addr = '0; c_if.req_wdata = '0;

      // Reset state, checked before any clock edge (async reset).
      #1 reset_n = 1'b0;
      #2;
      check("rst_ce_l", a_ce_l, 1);
      check("rst_oe_l", a_oe_l, 1);
      check("rst_we_l", a_we_l, 1);
      check("rst_d_oe", a_d_oe, 0);
      check("rst_ack", a_if.ack, 0);
      check("rst_busy", a_if.busy, 0);
      check("rst_rdata", a_if.rdata, 0);
      check("rst_sram_a", a_sram_a, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Single accesses from the table.
      for (int i = 0; i < 9; i++) begin
         a_access(vecs[i].ch, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, ack_v, rd, a_v, we_low);
         check($sformatf("v%0d_latency", i), lat, 3);
         check($sformatf("v%0d_ack", i), ack_v, vecs[i].exp_ack);
         check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("v%0d_sram_a", i), a_v, vecs[i].addr);
         check($sformatf("v%0d_we_low", i), we_low, vecs[i].we ? 2 : 0);
      end

      // Arbitration: ch0 and ch1 contend for 4 reads each.
      do_reset();
`ifdef SRAM_RR_ARB_EN
      for (int i = 0; i < 8; i++) exp_ord[i] = i % 2;
`else
      for (int i = 0; i < 8; i++) exp_ord[i] = (i < 4) ? 0 : 1;
`endif
      @(negedge clk);
      a_if.req_we[1:0] = 2'b00;
      a_if.req_addr[0 +: 19]  = 19'h00010;
      a_if.req_addr[19 +: 19] = 19'h00011;
      served[0] = 0; served[1] = 0; n_ord = 0; e = 0;
      a_if.req[1:0] = 2'b11;
      while (n_ord < 8 && e < 200) begin
         @(posedge clk); #1;
         e++;
         for (int c = 0; c < 2; c++) begin
            if (a_if.ack[c]) begin
               ord[n_ord] = c; n_ord++; served[c]++; a_if.req[c] = 1'b0;
            end else if (!a_if.req[c] && served[c] < 4) begin
               a_if.req[c] = 1'b1;
            end
         end
      end
      a_if.req = '0;
      check("arb_count", n_ord, 8);
      for (int i = 0; i < 8; i++) begin
         if (i < n_ord) check($sformatf("arb_order%0d", i), ord[i], exp_ord[i]);
      end

      // Write 0x1<-0x55 then read 0x0 back to back: d_oe drops a cycle before oe_l.
      a_wait_idle();
      a_if.req_we[1:0] = 2'b01;
      a_if.req_addr[0 +: 19]  = 19'h00001;
      a_if.req_wdata[0 +: 8]  = 8'h55;
      a_if.req_addr[19 +: 19] = 19'h00000;
      a_if.req[1:0] = 2'b11;
      n_h = 0; n_ack = 0; rd3 = '0;
      while (n_ack < 2 && n_h < 40) begin
         @(posedge clk); #1;
         doe_h[n_h] = a_d_oe; oel_h[n_h] = a_oe_l; n_h++;
         for (int c = 0; c < 2; c++) begin
            if (a_if.ack[c]) begin
               n_ack++; a_if.req[c] = 1'b0;
               if (c == 1) rd3 = a_if.rdata;
            end
         end
      end
      a_if.req = '0;
      doe_fall = -1; oe_fall = -1;
      for (int k = 1; k < n_h; k++) begin
         if (doe_fall < 0 && doe_h[k-1] && !doe_h[k]) doe_fall = k;
         if (oe_fall < 0 && oel_h[k-1] && !oel_h[k]) oe_fall = k;
      end
      check("t3_doe_to_oe_gap", oe_fall - doe_fall, 1);
      check("t3_rdata", rd3, 8'h11);

      // Reset during the strobe of a write.
      a_wait_idle();
      a_if.req_we[0] = 1'b1;
      a_if.req_addr[0 +: 19] = 19'h00002;
      a_if.req_wdata[0 +: 8] = 8'h77;
      a_if.req[0] = 1'b1;
      e = 0; hit = 1'b0;
      while (!hit && e < 20) begin
         @(posedge clk); #1;
         e++;
         hit = !a_we_l;
      end
      check("t5_strobe_reached", hit, 1);
      #1 reset_n = 1'b0;
      #1;
      check("t5_we_l", a_we_l, 1);
      check("t5_ce_l", a_ce_l, 1);
      check("t5_d_oe", a_d_oe, 0);
      a_if.req[0] = 1'b0;
      snap = a_ack_cum;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t5_no_ack", a_ack_cum - snap, 0);
      check("t5_busy", a_if.busy, 0);
      check("t5_rdata", a_if.rdata, 0);
      check("t5_sram_a", a_sram_a, 0);

      // WAIT_STATES 0 and 15: write pass then read pass.
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         b_if.req_we = (pass == 0) ? 1'b1 : 1'b0;
         c_if.req_we = (pass == 0) ? 1'b1 : 1'b0;
         b_if.req_addr = 19'd5;  c_if.req_addr = 19'd5;
         b_if.req_wdata = 8'h99; c_if.req_wdata = 8'h99;
         bw0 = b_we_cum; cw0 = c_we_cum; bo0 = b_oe_cum; co0 = c_oe_cum;
         b_done = 1'b0; c_done = 1'b0; b_lat = -1; c_lat = -1; b_rd = '0; c_rd = '0;
         b_if.req = 1'b1; c_if.req = 1'b1;
         for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!b_done && b_if.ack[0]) begin
               b_done = 1'b1; b_lat = k - 1; b_rd = b_if.rdata; b_if.req = 1'b0;
            end
            if (!c_done && c_if.ack[0]) begin
               c_done = 1'b1; c_lat = k - 1; c_rd = c_if.rdata; c_if.req = 1'b0;
            end
         end
         b_if.req = 1'b0; c_if.req = 1'b0;
         check($sformatf("ws0_latency_p%0d", pass), b_lat, 2);
         check($sformatf("ws15_latency_p%0d", pass), c_lat, 17);
         if (pass == 0) begin
            check("ws0_we_width", b_we_cum - bw0, 1);
            check("ws15_we_width", c_we_cum - cw0, 16);
         end else begin
            check("ws0_oe_width", b_oe_cum - bo0, 2);
            check("ws15_oe_width", c_oe_cum - co0, 17);
            check("ws0_rdata", b_rd, 8'hC3);
            check("ws15_rdata", c_rd, 8'h3C);
         end
      end

      check("d_oe_oe_overlap", overlap_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule
